// File: rtl/pipe_control_if.sv
// rtl/pipe_control_if.sv - hazard inputs and pipeline-control outputs of the Y86-64 control unit
interface pipe_control_if #(
    parameter int CNT_W = 32
);
    logic [3:0]       D_icode_i;
    logic [3:0]       d_srcA_i;
    logic [3:0]       d_srcB_i;
    logic [3:0]       E_icode_i;
    logic [3:0]       E_dstM_i;
    logic             e_cnd_i;
    logic [2:0]       m_stat_i;
    logic [2:0]       W_stat_i;
    logic             F_stall_o;
    logic             D_stall_o;
    logic             D_bubble_o;
    logic             E_bubble_o;
    logic             M_bubble_o;
    logic             W_stall_o;
    logic             set_cc_en_o;
    logic [2:0]       cpu_stat_o;
    logic             halted_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_cnd_i, m_stat_i, W_stat_i,
        input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
        input  set_cc_en_o, cpu_stat_o, halted_o, stall_cnt_o
    );

    modport slave (
        input  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_dstM_i, e_cnd_i, m_stat_i, W_stat_i,
        output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
        output set_cc_en_o, cpu_stat_o, halted_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_control.sv
// rtl/pipe_control.sv - Y86-64 pipeline hazard control, exception/halt FSM and stall counter
module pipe_control #(
    parameter int RET_BUBBLES = 3,
    parameter int CNT_W       = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pipe_control_if.slave  bus
);
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [2:0] SAOK    = 3'd1;
    localparam int         RC_W    = (RET_BUBBLES > 1) ? $clog2(RET_BUBBLES) : 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [RC_W-1:0]  r_ret_cnt;
    logic [2:0]       r_cpu_stat;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_lu, w_mp, w_ret_d, w_rt, w_stat_bad;
    logic w_f_stall, w_d_stall, w_d_bubble, w_e_bubble, w_m_bubble, w_w_stall, w_set_cc;

    assign w_lu = ((bus.E_icode_i == IMRMOVQ) || (bus.E_icode_i == IPOPQ)) &&
                  (bus.E_dstM_i != RNONE) &&
                  ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
    assign w_mp = (bus.E_icode_i == IJXX) && !bus.e_cnd_i;
    // A mispredicted jump squashes the ret sitting in D, so that ret raises no stall.
    assign w_ret_d    = (bus.D_icode_i == IRET) && !w_mp;
    assign w_rt       = w_ret_d || (r_ret_cnt != '0);
    assign w_stat_bad = (bus.m_stat_i != SAOK) || (bus.W_stat_i != SAOK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RUN: begin
                if (bus.W_stat_i != SAOK) begin
                    w_next = S_HALTED;
                end else if (bus.m_stat_i != SAOK) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.W_stat_i != SAOK) begin
                    w_next = S_HALTED;
                end
            end
            default: w_next = S_HALTED;
        endcase
    end

    always_comb begin
        w_f_stall  = 1'b0;
        w_d_stall  = 1'b0;
        w_d_bubble = 1'b0;
        w_e_bubble = 1'b0;
        w_m_bubble = 1'b0;
        w_w_stall  = 1'b0;
        w_set_cc   = 1'b1;
        if (!rst_i) begin
            if (r_state == S_HALTED) begin
                w_f_stall  = 1'b1;
                w_m_bubble = 1'b1;
                w_w_stall  = 1'b1;
                w_set_cc   = 1'b0;
            end else begin
                w_f_stall  = w_lu || w_rt;
                w_d_stall  = w_lu;
                w_d_bubble = w_mp || (w_rt && !w_lu);
                w_e_bubble = w_mp || w_lu;
                w_m_bubble = (r_state == S_DRAIN);
                w_set_cc   = (r_state == S_RUN) && !w_stat_bad;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state == S_HALTED)) begin
            r_ret_cnt <= '0;
        end else if ((bus.D_icode_i == IRET) && !w_lu && !w_mp && (r_ret_cnt == '0)) begin
            r_ret_cnt <= RC_W'(RET_BUBBLES - 1);
        end else if (r_ret_cnt != '0) begin
            r_ret_cnt <= r_ret_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cpu_stat <= SAOK;
        end else if ((r_state != S_HALTED) && (w_next == S_HALTED)) begin
            r_cpu_stat <= bus.W_stat_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && w_f_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.F_stall_o   = w_f_stall;
    assign bus.D_stall_o   = w_d_stall;
    assign bus.D_bubble_o  = w_d_bubble;
    assign bus.E_bubble_o  = w_e_bubble;
    assign bus.M_bubble_o  = w_m_bubble;
    assign bus.W_stall_o   = w_w_stall;
    assign bus.set_cc_en_o = w_set_cc;
    assign bus.cpu_stat_o  = r_cpu_stat;
    assign bus.halted_o    = (r_state == S_HALTED);
    assign bus.stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_pipe_control.sv
// tb/tb_pipe_control.sv - self-checking bench for pipe_control against a behavioural model
module tb_pipe_control;
    localparam int RB = 3;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_control_if #(.CNT_W(CW)) bus ();
    pipe_control #(.RET_BUBBLES(RB), .CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    // model: mode 0=run 1=drain 2=halted; ret_left = remaining ret stall cycles after the current one
    int m_mode, m_ret_left, m_cnt, m_stat;
    logic [6:0] obs, exp_v;
    logic [7:0] robs, rexp;

    function automatic logic hz_lu();
        return ((bus.E_icode_i == 4'd5) || (bus.E_icode_i == 4'd11)) && (bus.E_dstM_i != 4'hF) &&
               ((bus.E_dstM_i == bus.d_srcA_i) || (bus.E_dstM_i == bus.d_srcB_i));
    endfunction

    function automatic logic hz_mp();
        return (bus.E_icode_i == 4'd7) && !bus.e_cnd_i;
    endfunction

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en}
    function automatic logic [6:0] model_ctrl();
        logic lu, mp, rt;
        if (rst) return 7'b0000001;
        if (m_mode == 2) return 7'b1000110;
        lu = hz_lu();
        mp = hz_mp();
        rt = ((bus.D_icode_i == 4'd9) && !mp) || (m_ret_left > 0);
        return {lu | rt, lu, mp | (rt & !lu), mp | lu, m_mode == 1, 1'b0,
                (m_mode == 0) && (bus.m_stat_i == 3'd1) && (bus.W_stat_i == 3'd1)};
    endfunction

    function automatic logic [6:0] dut_ctrl();
        return {bus.F_stall_o, bus.D_stall_o, bus.D_bubble_o, bus.E_bubble_o,
                bus.M_bubble_o, bus.W_stall_o, bus.set_cc_en_o};
    endfunction

    function automatic logic [7:0] model_regs();
        return {m_mode == 2, 3'(m_stat), 4'(m_cnt)};
    endfunction

    task automatic model_clock();
        logic [6:0] c;
        logic lu, mp;
        if (rst) begin
            m_mode = 0; m_ret_left = 0; m_cnt = 0; m_stat = 1;
        end else begin
            c  = model_ctrl();
            lu = hz_lu();
            mp = hz_mp();
            if (m_mode == 0 && c[6] && m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_mode == 2) m_ret_left = 0;
            else if (bus.D_icode_i == 4'd9 && !lu && !mp && m_ret_left == 0) m_ret_left = RB - 1;
            else if (m_ret_left > 0) m_ret_left--;
            if (m_mode != 2) begin
                if (bus.W_stat_i != 3'd1) begin
                    m_mode = 2; m_stat = int'(bus.W_stat_i);
                end else if (bus.m_stat_i != 3'd1) m_mode = 1;
            end
        end
    endtask

    task automatic drive(input logic [3:0] d, sa, sb, e, dm, input logic cnd, input logic [2:0] ms, ws);
        bus.D_icode_i = d; bus.d_srcA_i = sa; bus.d_srcB_i = sb;
        bus.E_icode_i = e; bus.E_dstM_i = dm; bus.e_cnd_i = cnd;
        bus.m_stat_i = ms; bus.W_stat_i = ws;
        #1;
    endtask

    task automatic idle();
        drive(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 3'd1, 3'd1);
    endtask

    task automatic rand_inputs(input int exc_pct);
        logic [3:0] ic [8] = '{4'd1, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd2, 4'd4};
        logic [2:0] ms, ws;
        ms = ($urandom_range(0, 99) < exc_pct) ? 3'($urandom_range(2, 4)) : 3'd1;
        ws = ($urandom_range(0, 99) < exc_pct) ? 3'($urandom_range(2, 4)) : 3'd1;
        drive(ic[$urandom_range(0, 7)], 4'($urandom_range(0, 3)), 4'($urandom_range(0, 4)),
              ic[$urandom_range(0, 7)], ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), ms, ws);
    endtask

    task automatic advance();
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        obs = dut_ctrl();
        checks++;
        if (obs !== 7'b0000001) begin
            errors++; $display("FAIL reset_ctrl: got %b expected %b", obs, 7'b0000001);
        end
        advance();
        robs = {bus.halted_o, bus.cpu_stat_o, bus.stall_cnt_o};
        checks++;
        if (robs !== 8'b0_001_0000) begin
            errors++; $display("FAIL reset_regs: got %b expected %b", robs, 8'b0_001_0000);
        end
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(4'd6, 4'd0, 4'd3, 4'd5, 4'd0, 1'b0, 3'd1, 3'd1);
        obs = dut_ctrl(); exp_v = model_ctrl();
        checks++;
        if (obs !== exp_v || obs[6:3] !== 4'b1101) begin
            errors++; $display("FAIL load_use_ctrl: got %b expected %b", obs, exp_v);
        end
        advance();
        idle();
        checks++;
        if (bus.stall_cnt_o !== 4'd1 || dut_ctrl() !== 7'b0000001) begin
            errors++; $display("FAIL load_use_after: got cnt=%0d ctrl=%b expected cnt=1 ctrl=0000001",
                               bus.stall_cnt_o, dut_ctrl());
        end
    endtask

    task automatic test_ret();
        int stalls = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 0) drive(4'd9, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 3'd1, 3'd1);
            else idle();
            obs = dut_ctrl(); exp_v = model_ctrl();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL ret_cycle%0d: got %b expected %b", i, obs, exp_v);
            end
            if (obs[6] && obs[4]) stalls++;
            advance();
        end
        checks++;
        if (stalls != RB) begin
            errors++; $display("FAIL ret_total_stalls: got %0d expected %0d", stalls, RB);
        end
    endtask

    task automatic test_mispredict_ret();
        do_reset();
        drive(4'd9, 4'hF, 4'hF, 4'd7, 4'hF, 1'b0, 3'd1, 3'd1);
        obs = dut_ctrl();
        checks++;
        if (obs !== 7'b0011001) begin
            errors++; $display("FAIL mispredict_ret: got %b expected %b", obs, 7'b0011001);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            idle();
            obs = dut_ctrl();
            checks++;
            if (obs !== 7'b0000001) begin
                errors++; $display("FAIL mispredict_after%0d: got %b expected %b", i, obs, 7'b0000001);
            end
            advance();
        end
    endtask

    task automatic test_exception();
        do_reset();
        drive(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 3'd3, 3'd1);
        obs = dut_ctrl();
        checks++;
        if (obs !== 7'b0000000) begin
            errors++; $display("FAIL exc_mstat: got %b expected %b", obs, 7'b0000000);
        end
        advance();
        drive(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 3'd1, 3'd3);
        obs = dut_ctrl();
        checks++;
        if (obs !== 7'b0000100) begin
            errors++; $display("FAIL exc_drain: got %b expected %b", obs, 7'b0000100);
        end
        advance();
        robs = {bus.halted_o, bus.cpu_stat_o, bus.stall_cnt_o};
        checks++;
        if (robs[7:4] !== 4'b1_011) begin
            errors++; $display("FAIL exc_halted: got %b expected halted=1 stat=011", robs[7:4]);
        end
    endtask

    task automatic test_halt();
        do_reset();
        drive(4'd1, 4'hF, 4'hF, 4'd1, 4'hF, 1'b0, 3'd1, 3'd2);
        advance();
        for (int i = 0; i < 100; i++) begin
            rand_inputs(30);
            obs = dut_ctrl();
            robs = {bus.halted_o, bus.cpu_stat_o, bus.stall_cnt_o};
            checks++;
            if (obs !== 7'b1000110 || robs !== 8'b1_010_0000) begin
                errors++; $display("FAIL halt_hold%0d: got ctrl=%b regs=%b expected ctrl=1000110 regs=10100000",
                                   i, obs, robs);
            end
            advance();
        end
        do_reset();
        idle();
        robs = {bus.halted_o, bus.cpu_stat_o, bus.stall_cnt_o};
        checks++;
        if (robs !== 8'b0_001_0000 || dut_ctrl() !== 7'b0000001) begin
            errors++; $display("FAIL halt_reset: got regs=%b ctrl=%b expected regs=00010000 ctrl=0000001",
                               robs, dut_ctrl());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            rand_inputs(3);
            obs = dut_ctrl(); exp_v = model_ctrl();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL random_ctrl%0d: got %b expected %b", i, obs, exp_v);
            end
            advance();
            robs = {bus.halted_o, bus.cpu_stat_o, bus.stall_cnt_o}; rexp = model_regs();
            checks++;
            if (robs !== rexp) begin
                errors++; $display("FAIL random_regs%0d: got %b expected %b", i, robs, rexp);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(4'd6, 4'd2, 4'd2, 4'd11, 4'd2, 1'b0, 3'd1, 3'd1);
            advance();
        end
        robs = model_regs();
        checks++;
        if (bus.stall_cnt_o !== 4'hF || robs[3:0] !== 4'hF) begin
            errors++; $display("FAIL saturate: got %h expected f", bus.stall_cnt_o);
        end
        idle();
        advance();
        checks++;
        if (bus.stall_cnt_o !== 4'hF) begin
            errors++; $display("FAIL saturate_hold: got %h expected f", bus.stall_cnt_o);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_ret();
        test_mispredict_ret();
        test_exception();
        test_halt();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
